// File: rtl/uart_word_bridge.sv
// uart_word_bridge
//   Packs/unpacks NBITS-wide debug words to/from DBIT-wide UART bytes,
//   little-endian (byte 0 first on the wire). RX and TX run independently.
//   Optional build macro: UART_WORD_RX_TIMEOUT_EN adds an inter-byte RX
//   timeout that discards a partial word after TIMEOUT_CYCLES idle cycles.
//
// TX FSM states
//   state   | meaning
//   IDLE    | waiting for tx_start, latches tx_Data
//   SEND    | presents current byte and pulses uart_tx_start
//   WAIT    | waiting for uart_tx_done of the byte in flight
//   DONE    | last byte finished, pulses tx_done
//   REARM   | waits for tx_start to drop before accepting a new word
module uart_word_bridge #(
    parameter int NBITS          = 32,
    parameter int DBIT           = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBIT-1:0]  uart_rx_data,
    input  logic             uart_rx_done,
    input  logic             uart_tx_done,
    input  logic [NBITS-1:0] tx_Data,
    input  logic             tx_start,
    output logic [DBIT-1:0]  uart_tx_data,
    output logic             uart_tx_start,
    output logic [NBITS-1:0] rx_Data,
    output logic             rx_done,
    output logic             tx_done
);

    localparam int NB = NBITS / DBIT;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(NB - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_REARM = 3'd4;

    // Reject a word width that is not a whole number of bytes, or a zero timeout.
    if ((NBITS % DBIT) != 0 || NB < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_word_bridge: NBITS must be a non-zero multiple of DBIT and TIMEOUT_CYCLES >= 1");
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [CW-1:0]    rx_cnt;
    logic [CW-1:0]    rx_slot;
    logic [NBITS-1:0] rx_shift;
    logic [NBITS-1:0] rx_word;
    logic             rx_flush;

`ifdef UART_WORD_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] rx_tmr;

    // A partial word whose down-counter has run out is abandoned.
    assign rx_flush = (rx_cnt != '0) && (rx_tmr == '0);

    // Inter-byte timer: reload on every byte, count down while a word is partial.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_tmr <= '0;
        end else if (uart_rx_done) begin
            rx_tmr <= TW'(TIMEOUT_CYCLES - 1);
        end else if ((rx_cnt != '0) && (rx_tmr != '0)) begin
            rx_tmr <= rx_tmr - TW'(1);
        end
    end
`else
    assign rx_flush = 1'b0;
`endif

    // A byte arriving together with a timeout starts a fresh word.
    assign rx_slot = rx_flush ? '0 : rx_cnt;

    // Assembly register as it looks once the incoming byte lands in its slot.
    always_comb begin
        rx_word = rx_shift;
        for (int k = 0; k < NB; k++) begin
            if (rx_slot == CW'(k)) begin
                rx_word[k*DBIT +: DBIT] = uart_rx_data;
            end
        end
    end

    // Byte collection; rx_Data only ever shows complete words.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_Data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (uart_rx_done) begin
                rx_shift <= rx_word;
                if (rx_slot == LAST_SLOT) begin
                    rx_cnt  <= '0;
                    rx_Data <= rx_word;
                    rx_done <= 1'b1;
                end else begin
                    rx_cnt <= rx_slot + CW'(1);
                end
            end else if (rx_flush) begin
                rx_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [2:0]       tx_state;
    logic [CW-1:0]    tx_cnt;
    logic [NBITS-1:0] tx_shift;
    logic [DBIT-1:0]  tx_byte;

    // Byte of the latched word selected by tx_cnt.
    always_comb begin
        tx_byte = '0;
        for (int k = 0; k < NB; k++) begin
            if (tx_cnt == CW'(k)) begin
                tx_byte = tx_shift[k*DBIT +: DBIT];
            end
        end
    end

    // Word transmit sequencer; outputs are registered, uart_tx_data holds between bytes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state      <= S_IDLE;
            tx_cnt        <= '0;
            tx_shift      <= '0;
            uart_tx_data  <= '0;
            uart_tx_start <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            uart_tx_start <= 1'b0;
            tx_done       <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    if (tx_start) begin
                        tx_shift <= tx_Data;
                        tx_cnt   <= '0;
                        tx_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    uart_tx_data  <= tx_byte;
                    uart_tx_start <= 1'b1;
                    tx_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (uart_tx_done) begin
                        if (tx_cnt == LAST_SLOT) begin
                            tx_state <= S_DONE;
                        end else begin
                            tx_cnt   <= tx_cnt + CW'(1);
                            tx_state <= S_SEND;
                        end
                    end
                end
                S_DONE: begin
                    tx_done  <= 1'b1;
                    tx_state <= S_REARM;
                end
                S_REARM: begin
                    // tx_start is a level that the controller drops only after
                    // seeing tx_done; re-arming early would resend the word.
                    if (!tx_start) begin
                        tx_state <= S_IDLE;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Testbench for uart_word_bridge: word-level reference model for RX, byte
// scoreboard plus responder for TX, directed cases followed by random traffic.
// Expectations for the RX timeout case follow UART_WORD_RX_TIMEOUT_EN.
module tb_uart_word_bridge;

    localparam int NBITS = 32;
    localparam int DBIT  = 8;
    localparam int NB    = NBITS / DBIT;
    localparam int TOUT  = 50;

    logic             clk;
    logic             reset;
    logic [DBIT-1:0]  uart_rx_data;
    logic             uart_rx_done;
    logic             uart_tx_done;
    logic [NBITS-1:0] tx_Data;
    logic             tx_start;
    logic [DBIT-1:0]  uart_tx_data;
    logic             uart_tx_start;
    logic [NBITS-1:0] rx_Data;
    logic             rx_done;
    logic             tx_done;

    uart_word_bridge #(.NBITS(NBITS), .DBIT(DBIT), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx_data (uart_rx_data),
        .uart_rx_done (uart_rx_done),
        .uart_tx_done (uart_tx_done),
        .tx_Data      (tx_Data),
        .tx_start     (tx_start),
        .uart_tx_data (uart_tx_data),
        .uart_tx_start(uart_tx_start),
        .rx_Data      (rx_Data),
        .rx_done      (rx_done),
        .tx_done      (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    logic [7:0]  m_bytes[$];
    logic [31:0] m_data;
    logic        m_done;
    int          gap;
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  last_tx_byte;
    bit          first_pending;
    bit          tx_expect_done;
    int          req_cyc;
    int          last_txd_cyc;
    int          req_pending;
    int          resp_delay;
    int          n_tx_starts;
    int          n_tx_done;
    int          n_rx_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word-level model: bytes queue up until NB have arrived, then one word appears.
    initial begin
        m_data = '0; m_done = 1'b0; gap = 0; last_tx_byte = '0;
        first_pending = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                m_bytes.delete();
                exp_tx_q.delete();
                m_data        = '0;
                m_done        = 1'b0;
                gap           = 0;
                last_tx_byte  = '0;
                first_pending = 0;
            end else begin
                m_done = 1'b0;
                gap++;
`ifdef UART_WORD_RX_TIMEOUT_EN
                if (m_bytes.size() != 0 && gap >= TOUT) m_bytes.delete();
`endif
                if (uart_rx_done) begin
                    m_bytes.push_back(uart_rx_data);
                    gap = 0;
                    if (m_bytes.size() == NB) begin
                        logic [31:0] w;
                        w = '0;
                        for (int k = 0; k < NB; k++) w = w | (32'(m_bytes[k]) << (8 * k));
                        m_data = w;
                        m_done = 1'b1;
                        m_bytes.delete();
                    end
                end
            end
        end
    end

    // Per-cycle compare of all outputs against the model / scoreboard.
    initial begin
        n_tx_starts = 0; n_tx_done = 0; n_rx_done = 0; req_pending = 0;
        tx_expect_done = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rx_done", rx_done, m_done);
                chk("rx_Data", rx_Data, m_data);
                if (rx_done) n_rx_done++;
                if (uart_tx_start) begin
                    n_tx_starts++;
                    chk("tx_start_expected", exp_tx_q.size() != 0, 1);
                    if (exp_tx_q.size() != 0) chk("tx_byte", uart_tx_data, exp_tx_q.pop_front());
                    if (first_pending) begin
                        chk("tx_start_latency", cyc - req_cyc, 2);
                        first_pending = 0;
                    end
                    last_tx_byte = uart_tx_data;
                    tx_log.push_back(uart_tx_data);
                    req_pending++;
                end else begin
                    chk("tx_data_hold", uart_tx_data, last_tx_byte);
                end
                if (tx_done) begin
                    n_tx_done++;
                    chk("tx_done_expected", tx_expect_done, 1);
                    chk("tx_done_latency", cyc - last_txd_cyc, 2);
                    tx_expect_done = 0;
                end
            end
        end
    end

    // UART transmitter stand-in: answers each uart_tx_start after resp_delay cycles.
    initial begin
        uart_tx_done = 1'b0;
        forever begin
            @(posedge clk);
            if (req_pending > 0) begin
                req_pending--;
                if (resp_delay > 1) repeat (resp_delay - 1) @(posedge clk);
                #1;
                uart_tx_done = 1'b1;
                last_txd_cyc = cyc;
                @(posedge clk);
                #1;
                uart_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_rx(input logic [7:0] b);
        uart_rx_data = b;
        uart_rx_done = 1'b1;
        @(posedge clk); #1;
        uart_rx_done = 1'b0;
    endtask

    task automatic tx_word(input logic [31:0] w, input int dly, input int extra);
        int  waited;
        bit  seen;
        int  base;
        resp_delay = dly;
        for (int k = 0; k < NB; k++) exp_tx_q.push_back(w[8*k +: 8]);
        base           = n_tx_starts;
        tx_Data        = w;
        tx_start       = 1'b1;
        req_cyc        = cyc;
        first_pending  = 1;
        tx_expect_done = 1;
        seen = 0; waited = 0;
        while (!seen && waited < 400) begin
            @(negedge clk);
            waited++;
            if (waited == 3) tx_Data = ~w;
            if (tx_done) seen = 1;
        end
        chk("tx_done_seen", seen, 1);
        chk("tx_bytes_per_word", n_tx_starts - base, NB);
        @(posedge clk); #1;
        repeat (extra) begin @(posedge clk); #1; end
        tx_start = 1'b0;
        @(negedge clk);
        chk("tx_no_resend", n_tx_starts - base, NB);
        @(posedge clk); #1;
    endtask

    initial begin
        int base_rx, base_tx, base_done, waited;
        logic [31:0] packed_log;
        reset = 1'b0; uart_rx_data = '0; uart_rx_done = 1'b0;
        tx_Data = '0; tx_start = 1'b0; resp_delay = 10; last_txd_cyc = 0; req_cyc = 0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {uart_tx_data, uart_tx_start, rx_Data, rx_done, tx_done}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);

        // 1: single word
        base_rx = n_rx_done;
        send_rx(8'h78); send_rx(8'h56); send_rx(8'h34); send_rx(8'h12);
        idle(3);
        @(negedge clk);
        chk("t1_rx_Data", rx_Data, 32'h12345678);
        chk("t1_rx_done_low", rx_done, 0);
        chk("t1_pulses", n_rx_done - base_rx, 1);
        @(posedge clk); #1;

        // 2: back-to-back, byte 0 of word 2 alongside rx_done
        base_rx = n_rx_done;
        for (int i = 0; i < 8; i++) send_rx(8'hFF);
        idle(2);
        @(negedge clk);
        chk("t2_rx_Data", rx_Data, 32'hFFFFFFFF);
        chk("t2_pulses", n_rx_done - base_rx, 2);
        @(posedge clk); #1;

        // 3: one word, tx_start held one extra cycle after tx_done
        tx_log.delete();
        base_done = n_tx_done;
        tx_word(32'hDEADBEEF, 10, 1);
        packed_log = (tx_log.size() == 4) ? {tx_log[3], tx_log[2], tx_log[1], tx_log[0]} : '0;
        chk("t3_byte_count", tx_log.size(), 4);
        chk("t3_bytes", packed_log, 32'hDEADBEEF);
        chk("t3_tx_done_pulses", n_tx_done - base_done, 1);

        // 4: controller loop, one low cycle then next word
        tx_log.delete();
        tx_word(32'h00000001, 10, 0);
        packed_log = (tx_log.size() == 4) ? {tx_log[3], tx_log[2], tx_log[1], tx_log[0]} : '0;
        chk("t4_bytes", packed_log, 32'h00000001);
        chk("t4_tx_done_pulses", n_tx_done - base_done, 2);

        // 5: reset in the middle of both paths
        resp_delay = 10;
        base_tx = n_tx_starts;
        for (int k = 0; k < NB; k++) exp_tx_q.push_back(8'(32'hCAFEF00D >> (8 * k)));
        tx_Data = 32'hCAFEF00D; tx_start = 1'b1; req_cyc = cyc; first_pending = 1; tx_expect_done = 1;
        send_rx(8'h5A); send_rx(8'hA5);
        waited = 0;
        while (n_tx_starts < base_tx + 3 && waited < 200) begin idle(1); waited++; end
        chk("t5_reached_byte2", n_tx_starts - base_tx, 3);
        idle(2);
        reset = 1'b0; tx_start = 1'b0; tx_expect_done = 0;
        idle(1);
        @(negedge clk);
        chk("t5_reset_outputs", {uart_tx_data, uart_tx_start, rx_Data, rx_done, tx_done}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        base_done = n_tx_done;
        idle(15);
        chk("t5_tx_idle", n_tx_starts - base_tx, 3);
        chk("t5_no_tx_done", n_tx_done - base_done, 0);
        send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
        idle(2);
        @(negedge clk);
        chk("t5_rx_Data", rx_Data, 32'h04030201);
        @(posedge clk); #1;
        tx_log.delete();
        tx_word(32'h0BADF00D, 3, 0);
        packed_log = (tx_log.size() == 4) ? {tx_log[3], tx_log[2], tx_log[1], tx_log[0]} : '0;
        chk("t5_tx_after_reset", packed_log, 32'h0BADF00D);

        // 6: long inter-byte gap
        base_rx = n_rx_done;
        send_rx(8'h11); send_rx(8'h22);
        idle(60);
        send_rx(8'hAA); send_rx(8'hBB); send_rx(8'hCC); send_rx(8'hDD);
        idle(3);
        @(negedge clk);
        chk("t6_pulses", n_rx_done - base_rx, 1);
`ifdef UART_WORD_RX_TIMEOUT_EN
        chk("t6_rx_Data", rx_Data, 32'hDDCCBBAA);
        @(posedge clk); #1;
`else
        chk("t6_rx_Data", rx_Data, 32'hBBAA2211);
        @(posedge clk); #1;
        send_rx(8'h33); send_rx(8'h44);
        idle(2);
        @(negedge clk);
        chk("t6_pending_completed", rx_Data, 32'h4433DDCC);
        @(posedge clk); #1;
`endif
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(2);

        // random concurrent traffic on both paths
        fork
            begin
                repeat (40) begin
                    send_rx(8'($urandom));
                    idle($urandom_range(0, 3));
                end
            end
            begin
                repeat (6) begin
                    tx_word($urandom, $urandom_range(1, 6), $urandom_range(0, 2));
                end
            end
        join
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_word_bridge.md
Name: uart_word_bridge

Overview:
Sits between the 8-bit UART core and the debug controller.
- RX path: packs four UART bytes into a 32-bit word and presents it on rx_Data/rx_done.
- TX path: accepts a 32-bit word on tx_Data/tx_start, sends it as four UART bytes, then reports completion on tx_done.
- RX and TX paths run independently and concurrently.

Parameters:
NBITS, 32, word width seen by the debug controller.
DBIT, 8, UART byte width; NBITS must be a multiple of DBIT; NB = NBITS/DBIT bytes per word (localparam).
TIMEOUT_CYCLES, 100000, inter-byte RX timeout in clk cycles (used only with the optional feature).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset.
uart_rx_data  in  DBIT  byte from UART receiver.
uart_rx_done  in  1  one-cycle pulse, uart_rx_data valid.
uart_tx_done  in  1  one-cycle pulse, UART transmitter finished the current byte.
tx_Data  in  NBITS  word to transmit.
tx_start  in  1  level request; held high by the controller until it sees tx_done.
uart_tx_data  out  DBIT  byte to UART transmitter.
uart_tx_start  out  1  one-cycle pulse starting a UART byte.
rx_Data  out  NBITS  assembled word.
rx_done  out  1  one-cycle pulse, rx_Data holds a new word.
tx_done  out  1  one-cycle pulse, word fully transmitted.

Behaviour:
Reset (reset==0 sampled at a clk edge):
- All outputs go to 0.
- Byte counters go to 0; TX FSM goes to IDLE.
- Takes precedence over every other event and aborts any partial word on either path without emitting rx_done or tx_done.

Byte order: little-endian on both paths. Byte k maps to word bits [DBIT*k+DBIT-1 : DBIT*k], with k=0 first on the wire.

RX path:
- Registers: rx_cnt (0..NB-1) and a shift/assembly register.
- Each uart_rx_done: store the byte in slot rx_cnt, then rx_cnt++.
- When the byte landing in slot NB-1 is stored:
  - rx_Data is updated to the full word on the next edge, and rx_done is high for exactly that one cycle.
  - rx_cnt wraps to 0.
- rx_Data holds its value until the next full word completes. Partial words are never visible on rx_Data.
- A uart_rx_done in the same cycle rx_done is high is accepted normally as byte 0 of the next word.

TX path FSM:
- IDLE: tx_start==1 → latch tx_Data into tx_shift, tx_cnt=0 → SEND.
- SEND: uart_tx_data = tx_shift[tx_cnt slot]; uart_tx_start=1 for this one cycle → WAIT.
- WAIT: uart_tx_start=0.
  - On uart_tx_done with tx_cnt<NB-1: tx_cnt++ → SEND.
  - On uart_tx_done with tx_cnt==NB-1 → DONE.
- DONE: tx_done=1 for exactly one cycle → REARM.
- REARM: stay until tx_start==0 is sampled → IDLE. This prevents retransmitting the same word while the controller's registered tx_start is still high.

TX rules:
- Latency: uart_tx_start pulses 2 cycles after tx_start is first sampled high in IDLE. tx_done pulses the cycle after DONE is entered, i.e. 2 cycles after the last uart_tx_done.
- tx_Data changes after latching are ignored until the next IDLE.
- uart_tx_done outside WAIT is ignored.
- uart_tx_data holds the last byte sent between bytes.

Optional Feature:
Macro: UART_WORD_RX_TIMEOUT_EN.
- Defined: a counter restarts at each uart_rx_done and increments while rx_cnt!=0. When it reaches TIMEOUT_CYCLES, rx_cnt is cleared and the partial word is discarded; no rx_done, rx_Data unchanged. A uart_rx_done in the same cycle as the timeout is treated as byte 0 of a new word.
- Not defined: no counter exists; a partial word waits indefinitely for its remaining bytes.

Test Plan:
1. Bytes 0x78,0x56,0x34,0x12 on uart_rx_done → one rx_done pulse, rx_Data=0x12345678, held after the pulse.
2. Eight bytes 0xFF back-to-back, with the 5th uart_rx_done in the same cycle as rx_done → two rx_done pulses, rx_Data=0xFFFFFFFF each time, no byte lost.
3. tx_Data=0xDEADBEEF with tx_start held high; bench answers each uart_tx_start with uart_tx_done 10 cycles later → bytes EF,BE,AD,DE in order, one tx_done pulse, no 5th uart_tx_start while tx_start stays high for 1 extra cycle.
4. Controller-style loop: tx_start drops for one cycle after tx_done and rises again with tx_Data=0x00000001 → second word sent as bytes 01,00,00,00.
5. Reset pulled low after 2 RX bytes and mid-TX byte 2 → all outputs 0, TX FSM in IDLE. Then 4 new RX bytes 0x01..0x04 → rx_Data=0x04030201.
6. With UART_WORD_RX_TIMEOUT_EN defined and TIMEOUT_CYCLES=50: 2 bytes, 60-cycle gap, then 4 bytes 0xAA,0xBB,0xCC,0xDD → exactly one rx_done, rx_Data=0xDDCCBBAA. Without the macro, the same stimulus gives rx_Data=0xBBAA<byte1><byte0> and 2 bytes left pending.
